// File: rtl/mips_mem_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_pkg
// Shared types for the MEM-stage store buffer.
//   SB_DEPTH_DEFAULT : default number of queued stores
//   sb_entry_t       : one queued store {addr, data} at the 32-bit geometry
//   sb_state_t       : store buffer controller state {IDLE, DRAIN, FLUSH}
// ---------------------------------------------------------------------------
package mips_mem_pkg;

    localparam int SB_DEPTH_DEFAULT = 4;
    localparam int SB_AW            = 32;
    localparam int SB_DW            = 32;

    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;

    // Explicit encodings keep the state readable on a debug probe.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } sb_state_t;

endpackage

// File: rtl/store_buffer_cam.sv
// ---------------------------------------------------------------------------
// store_buffer_cam
// Compares a load address against every valid store buffer entry and
// returns the data of the youngest matching entry.
//   entry_addr / entry_data : entry storage, indexed by slot
//   valid                   : per-slot valid mask
//   tail                    : next write slot (the youngest entry is tail-1)
//   ld_addr                 : load address to look up
//   hit                     : at least one valid entry matches
//   data                    : data of the youngest match, 0 when no hit
// ---------------------------------------------------------------------------
module store_buffer_cam #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic [AW-1:0]              entry_addr [DEPTH],
    input  logic [DW-1:0]              entry_data [DEPTH],
    input  logic [DEPTH-1:0]           valid,
    input  logic [$clog2(DEPTH)-1:0]   tail,
    input  logic [AW-1:0]              ld_addr,
    output logic                       hit,
    output logic [DW-1:0]              data
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    // Walk the ring starting at tail, which is the oldest slot position, so
    // a later (younger) match simply overrides an earlier one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = tail + PW'(k);
            if (valid[idx] && (entry_addr[idx] == ld_addr)) begin
                hit  = 1'b1;
                data = entry_data[idx];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
// Posted-write buffer between EX/MEM and the data memory. Stores are queued
// in order and retired whenever the MEM-stage load does not own the memory
// port. Loads that hit a queued store are forwarded (SB_FWD_EN defined) or
// stalled until the matching stores have drained (SB_FWD_EN undefined).
//
// Handshake: a store is taken on a clock edge where st_valid && st_ready.
// st_ready is registered and never depends on ld_req; a store offered with
// st_ready low is ignored and the pipeline must hold it.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   st_valid/st_addr/st_data   store from MEM; st_ready accepts it
//   ld_req/ld_addr             MEM-stage load using the memory port
//   fwd_hit/fwd_data           forwarded load data
//   ld_stall                   hold the load in MEM
//   flush_req                  drain every queued entry
//   sb_empty                   nothing queued (registered)
//   dm_mem_write/dm_address/dm_data_write   data memory write port
// Configuration macro: SB_FWD_EN
// ---------------------------------------------------------------------------
module store_buffer
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_valid,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    output logic          st_ready,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    output logic          fwd_hit,
    output logic [DW-1:0] fwd_data,
    output logic          ld_stall,
    input  logic          flush_req,
    output logic          sb_empty,
    output logic          dm_mem_write,
    output logic [AW-1:0] dm_address,
    output logic [DW-1:0] dm_data_write
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    sb_state_t        state_q;
    sb_state_t        state_d;
    logic             st_ready_q;
    logic             sb_empty_q;
    logic [DEPTH-1:0] valid;
    logic             push;
    logic             pop;
    logic             flushing;
    logic             cam_hit;
    logic [DW-1:0]    cam_data;

    assign flushing = (state_q == FLUSH);
    assign push     = st_valid && st_ready_q;
    assign st_ready = st_ready_q;
    assign sb_empty = sb_empty_q;

    // Slot i is live when its distance from head is below the count.
    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid[i] = ({1'b0, PW'(i) - head_q} < count_q);
        end
    end

    store_buffer_cam #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_cam (
        .entry_addr (addr_q),
        .entry_data (data_q),
        .valid      (valid),
        .tail       (tail_q),
        .ld_addr    (ld_addr),
        .hit        (cam_hit),
        .data       (cam_data)
    );

`ifdef SB_FWD_EN
    assign fwd_hit  = ld_req && cam_hit;
    assign fwd_data = fwd_hit ? cam_data : '0;
    // Only a flush takes the port away from a load.
    assign ld_stall = flushing && ld_req;
`else
    logic unused_cam_data;
    assign unused_cam_data = ^cam_data;
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
    // The load waits while any older store to its address is still queued;
    // the stall itself grants the port to the buffer so the match drains.
    assign ld_stall = ld_req && (flushing || cam_hit);
`endif

    // Retire the head whenever the load is absent or held back.
    assign pop           = (count_q != '0) && (!ld_req || ld_stall);
    assign dm_mem_write  = pop;
    assign dm_address    = pop ? addr_q[head_q] : '0;
    assign dm_data_write = pop ? data_q[head_q] : '0;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (flush_req) begin
            state_d = FLUSH;
        end else begin
            case (state_q)
                IDLE:    if (push)            state_d = DRAIN;
                DRAIN:   if (count_d == '0)   state_d = IDLE;
                FLUSH:   if (count_d == '0)   state_d = IDLE;
                default:                      state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            st_ready_q <= 1'b1;
            sb_empty_q <= 1'b1;
        end else begin
            if (push) tail_q <= tail_q + PW'(1);
            if (pop)  head_q <= head_q + PW'(1);
            count_q    <= count_d;
            state_q    <= state_d;
            st_ready_q <= (count_d != FULL_COUNT) && (state_d != FLUSH);
            sb_empty_q <= (count_d == '0);
        end
    end

    // Entry storage needs no reset: the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= st_addr;
            data_q[tail_q] <= st_data;
        end
    end

    // Only one instruction occupies MEM; a store offered together with a
    // load is still taken, but the pipeline has misbehaved.
    a_no_store_with_load : assert property (
        @(posedge clk) disable iff (rst) !(st_valid && ld_req)
    ) else $warning("store_buffer: st_valid and ld_req asserted together");

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
    import mips_mem_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_ready;
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic          ld_stall;
    logic          flush_req;
    logic          sb_empty;
    logic          dm_mem_write;
    logic [AW-1:0] dm_address;
    logic [DW-1:0] dm_data_write;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .st_valid      (st_valid),
        .st_addr       (st_addr),
        .st_data       (st_data),
        .st_ready      (st_ready),
        .ld_req        (ld_req),
        .ld_addr       (ld_addr),
        .fwd_hit       (fwd_hit),
        .fwd_data      (fwd_data),
        .ld_stall      (ld_stall),
        .flush_req     (flush_req),
        .sb_empty      (sb_empty),
        .dm_mem_write  (dm_mem_write),
        .dm_address    (dm_address),
        .dm_data_write (dm_data_write)
    );

    // Data memory fed by the DUT write port (all test addresses are < 256).
    logic [DW-1:0] dm_mem [256];
    always @(posedge clk) if (dm_mem_write) dm_mem[dm_address[7:0]] <= dm_data_write;

    // ---------------- reference model / scoreboard ----------------
    logic [AW+DW-1:0] exp_q[$];      // queued stores, oldest first
    bit               m_flush;       // model is draining for a flush
    logic [DW-1:0]    exp_dm [256];  // expected data memory contents

    int checks = 0;
    int passes = 0;

    // Values seen at the last sample point, for hand-written expectations.
    logic          act_ready, act_empty, act_hit, act_stall, act_wr;
    logic [DW-1:0] act_fdata, act_wdata;
    logic [AW-1:0] act_waddr;
    logic [1:0]    act_state;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // One clock cycle: drive inputs, predict outputs from the model, sample
    // on the falling edge, then advance the model across the rising edge.
    task automatic step(input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                        input logic lr, input logic [AW-1:0] la, input logic fl, input logic r);
        sb_entry_t     e;
        bit            e_ready, e_empty, match, e_hit, e_stall, e_wr;
        logic [DW-1:0] mdata, e_fdata;
        logic [AW-1:0] e_waddr;
        logic [DW-1:0] e_wdata;
        logic [1:0]    e_state;
        st_valid = sv; st_addr = sa; st_data = sd;
        ld_req = lr; ld_addr = la; flush_req = fl; rst = r;

        e_empty = (exp_q.size() == 0);
        e_ready = (exp_q.size() < DEPTH) && !m_flush;
        match = 1'b0; mdata = '0;
        foreach (exp_q[i]) begin
            e = sb_entry_t'(exp_q[i]);
            if (e.addr == la) begin match = 1'b1; mdata = e.data; end
        end
`ifdef SB_FWD_EN
        e_hit   = lr && match;
        e_fdata = e_hit ? mdata : '0;
        e_stall = lr && m_flush;
`else
        e_hit   = 1'b0;
        e_fdata = '0;
        e_stall = lr && (m_flush || match);
`endif
        e_wr    = !e_empty && (!lr || e_stall);
        e_waddr = '0; e_wdata = '0;
        if (e_wr) begin
            e = sb_entry_t'(exp_q[0]);
            e_waddr = e.addr; e_wdata = e.data;
        end
        e_state = m_flush ? FLUSH : (e_empty ? IDLE : DRAIN);

        @(negedge clk);
        act_ready = st_ready; act_empty = sb_empty; act_hit = fwd_hit;
        act_fdata = fwd_data; act_stall = ld_stall; act_wr = dm_mem_write;
        act_waddr = dm_address; act_wdata = dm_data_write; act_state = dut.state_q;
        check("st_ready", act_ready, e_ready);
        check("sb_empty", act_empty, e_empty);
        check("fwd_hit", act_hit, e_hit);
        check("fwd_data", act_fdata, e_fdata);
        check("ld_stall", act_stall, e_stall);
        check("dm_mem_write", act_wr, e_wr);
        check("dm_address", act_waddr, e_waddr);
        check("dm_data_write", act_wdata, e_wdata);
        check("state", act_state, e_state);

        @(posedge clk);
        if (e_wr) begin
            exp_dm[e_waddr[7:0]] = e_wdata;
            void'(exp_q.pop_front());
        end
        if (r) begin
            exp_q.delete();
            m_flush = 1'b0;
        end else begin
            if (sv && e_ready) exp_q.push_back({sa, sd});
            m_flush = fl || (m_flush && exp_q.size() != 0);
        end
        #1;
    endtask

    task automatic idle(input logic lr, input logic [AW-1:0] la);
        step(1'b0, '0, '0, lr, la, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 2 * DEPTH + 2; k++) begin
            if (exp_q.size() == 0 && !m_flush) break;
            idle(1'b0, '0);
        end
        idle(1'b0, '0);
        check("drain_empty", act_empty, 1'b1);
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct {
        logic          sv;
        logic [AW-1:0] sa;
        logic [DW-1:0] sd;
        logic          exp_wr;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        logic          exp_empty;
    } vec_t;

    vec_t vecs [5];

    initial begin
        for (int i = 0; i < 256; i++) begin dm_mem[i] = '0; exp_dm[i] = '0; end
        st_valid = 0; st_addr = '0; st_data = '0; ld_req = 0; ld_addr = '0; flush_req = 0;
        m_flush = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values
        idle(1'b0, '0);
        check("rst_st_ready", act_ready, 1'b1);
        check("rst_sb_empty", act_empty, 1'b1);
        check("rst_dm_mem_write", act_wr, 1'b0);
        check("rst_fwd_data", act_fdata, '0);

        // Three stores retire back to back with no loads.
        vecs[0] = '{1'b1, 32'd5, 32'hA, 1'b0, 32'd0, 32'h0, 1'b1};
        vecs[1] = '{1'b1, 32'd6, 32'hB, 1'b1, 32'd5, 32'hA, 1'b0};
        vecs[2] = '{1'b1, 32'd7, 32'hC, 1'b1, 32'd6, 32'hB, 1'b0};
        vecs[3] = '{1'b0, 32'd0, 32'h0, 1'b1, 32'd7, 32'hC, 1'b0};
        vecs[4] = '{1'b0, 32'd0, 32'h0, 1'b0, 32'd0, 32'h0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            step(vecs[i].sv, vecs[i].sa, vecs[i].sd, 1'b0, '0, 1'b0, 1'b0);
            check("vec_wr", act_wr, vecs[i].exp_wr);
            check("vec_addr", act_waddr, vecs[i].exp_addr);
            check("vec_data", act_wdata, vecs[i].exp_data);
            check("vec_empty", act_empty, vecs[i].exp_empty);
        end
        check("dm5", dm_mem[5], 32'hA);
        check("dm6", dm_mem[6], 32'hB);
        check("dm7", dm_mem[7], 32'hC);

        // Fill while a non-matching load owns the port.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h20 + i, 32'h100 + i, 1'b1, 32'h80, 1'b0, 1'b0);
        idle(1'b1, 32'h80);
        check("full_not_ready", act_ready, 1'b0);
        check("full_no_write", act_wr, 1'b0);
        step(1'b1, 32'h30, 32'h99, 1'b0, '0, 1'b0, 1'b0);   // ignored store, pop
        check("full_pop", act_wr, 1'b1);
        step(1'b1, 32'h30, 32'h99, 1'b0, '0, 1'b0, 1'b0);   // push and pop together
        check("pushpop_ready", act_ready, 1'b1);
        check("pushpop_wr", act_wr, 1'b1);
        idle(1'b1, 32'h80);
        check("pushpop_count_held", act_ready, 1'b1);
        drain();

        // Two stores to the same address, then a load of it.
        step(1'b1, 32'd9, 32'd1, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 32'd9, 32'd2, 1'b1, 32'h80, 1'b0, 1'b0);
        idle(1'b1, 32'd9);
`ifdef SB_FWD_EN
        check("fwd_hit9", act_hit, 1'b1);
        check("fwd_data9", act_fdata, 32'd2);
        check("fwd_nostall", act_stall, 1'b0);
        check("fwd_nowrite", act_wr, 1'b0);
        drain();
        check("dm9_fwd", dm_mem[9], 32'd2);
`else
        check("stall1", act_stall, 1'b1);
        check("stall1_data", act_wdata, 32'd1);
        idle(1'b1, 32'd9);
        check("stall2", act_stall, 1'b1);
        check("stall2_data", act_wdata, 32'd2);
        idle(1'b1, 32'd9);
        check("stall_drop", act_stall, 1'b0);
        check("load_dm9", dm_mem[9], 32'd2);
`endif

        // Flush with three entries and a load held on the port.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h40 + i, 32'h200 + i, 1'b1, 32'h80, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 32'h80, 1'b1, 1'b0);
        check("flush_req_nowrite", act_wr, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1, 32'h80);
            check("flush_not_ready", act_ready, 1'b0);
            check("flush_write", act_wr, 1'b1);
            check("flush_addr", act_waddr, 32'h40 + i);
            check("flush_state", act_state, FLUSH);
        end
        idle(1'b1, 32'h80);
        check("flush_idle", act_state, IDLE);
        check("flush_empty", act_empty, 1'b1);

        // Reset with two entries queued.
        step(1'b1, 32'h50, 32'h300, 1'b1, 32'h80, 1'b0, 1'b0);
        step(1'b1, 32'h51, 32'h301, 1'b1, 32'h80, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 32'h80, 1'b0, 1'b1);
        idle(1'b0, '0);
        check("rst_q_empty", act_empty, 1'b1);
        check("rst_q_nowrite", act_wr, 1'b0);
        check("rst_dm50", dm_mem[8'h50], '0);
        check("rst_dm51", dm_mem[8'h51], '0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic sv, lr, fl, r;
            sv = ($urandom_range(0, 1) == 1);
            lr = sv ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            fl = ($urandom_range(0, 39) == 0);
            r  = ($urandom_range(0, 99) == 0);
            step(sv, AW'($urandom_range(0, 7)), $urandom, lr, AW'($urandom_range(0, 7)), fl, r);
        end
        drain();
        for (int i = 0; i < 256; i++) check("dm_final", dm_mem[i], exp_dm[i]);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
